// File: rtl/vga_rect_renderer.sv
// vga_rect_renderer: N-channel rectangle renderer with per-frame shadow geometry, fixed priority and overlap detection
module vga_rect_renderer #(
    parameter int N_RECT = 9,
    parameter int CW = 10,
    parameter int H_MAX = 640,
    parameter int V_MAX = 480,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [N_RECT*CW-1:0]   rect_cx,
    input  logic [N_RECT*CW-1:0]   rect_cy,
    input  logic [N_RECT*CW-1:0]   rect_hw,
    input  logic [N_RECT*CW-1:0]   rect_hh,
    input  logic [N_RECT-1:0]      rect_en,
    input  logic [3*N_RECT-1:0]    rect_color,
    input  logic [CW-1:0]          counter_x,
    input  logic [CW-1:0]          counter_y,
    input  logic                   in_display,
    output logic                   vga_r,
    output logic                   vga_g,
    output logic                   vga_b,
    output logic                   collision,
    output logic [N_RECT-1:0]      collision_mask
);
    localparam logic [CW:0] XLIM = (CW+1)'(H_MAX - 1);
    localparam logic [CW:0] YLIM = (CW+1)'(V_MAX - 1);
    logic [CW:0] lx [N_RECT];
    logic [CW:0] rx [N_RECT];
    logic [CW:0] ty [N_RECT];
    logic [CW:0] by [N_RECT];
    logic [CW-1:0] l_n [N_RECT];
    logic [CW-1:0] r_n [N_RECT];
    logic [CW-1:0] t_n [N_RECT];
    logic [CW-1:0] b_n [N_RECT];
    logic [2:0] col_n [N_RECT];
    logic [N_RECT-1:0] en_n;
    logic [CW-1:0] l_s [N_RECT];
    logic [CW-1:0] r_s [N_RECT];
    logic [CW-1:0] t_s [N_RECT];
    logic [CW-1:0] b_s [N_RECT];
    logic [2:0] col_s [N_RECT];
    logic [N_RECT-1:0] en_s;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic d1;
    logic [N_RECT-1:0] hit;
    logic [N_RECT-1:0] ovl;
    logic [N_RECT-1:0] acc;
    logic [2:0] pix;

    genvar g;
    generate
        for (g = 0; g < N_RECT; g++) begin : g_ch
            assign lx[g] = {1'b0, rect_cx[g*CW +: CW]} - {1'b0, rect_hw[g*CW +: CW]};
            assign rx[g] = {1'b0, rect_cx[g*CW +: CW]} + {1'b0, rect_hw[g*CW +: CW]};
            assign ty[g] = {1'b0, rect_cy[g*CW +: CW]} - {1'b0, rect_hh[g*CW +: CW]};
            assign by[g] = {1'b0, rect_cy[g*CW +: CW]} + {1'b0, rect_hh[g*CW +: CW]};
            assign l_n[g] = lx[g][CW] ? '0 : lx[g][CW-1:0];
            assign r_n[g] = rx[g] > XLIM ? XLIM[CW-1:0] : rx[g][CW-1:0];
            assign t_n[g] = ty[g][CW] ? '0 : ty[g][CW-1:0];
            assign b_n[g] = by[g] > YLIM ? YLIM[CW-1:0] : by[g][CW-1:0];
            assign en_n[g] = rect_en[g] & (lx[g] <= XLIM | lx[g][CW]) & (ty[g] <= YLIM | ty[g][CW]);
            assign col_n[g] = rect_color[g*3 +: 3];
            assign hit[g] = en_s[g] & d1 & (x1 >= l_s[g]) & (x1 <= r_s[g]) & (y1 >= t_s[g]) & (y1 <= b_s[g]);
        end
    endgenerate

    assign ovl = {hit[N_RECT-1:1] & {(N_RECT-1){hit[0]}}, 1'b0};

    // latch clamped edges, enable and colour once per frame
    always_ff @(posedge clk)
        if (reset) begin
            en_s <= '0;
        end else if (frame_start) begin
            en_s <= en_n;
            l_s <= l_n;
            r_s <= r_n;
            t_s <= t_n;
            b_s <= b_n;
            col_s <= col_n;
        end

    // lowest-index hit wins; background otherwise
    always_comb begin
        pix = BG_COLOR;
        for (int i = N_RECT - 1; i >= 0; i--) pix = hit[i] ? col_s[i] : pix;
    end

    // two-stage pixel pipeline: sampled coordinates, then registered colour
    always_ff @(posedge clk)
        if (reset) begin
            x1 <= '0;
            y1 <= '0;
            d1 <= 1'b0;
            {vga_r, vga_g, vga_b} <= 3'b000;
        end else begin
            x1 <= counter_x;
            y1 <= counter_y;
            d1 <= in_display;
            {vga_r, vga_g, vga_b} <= pix;
        end

    // accumulate overlaps with channel 0 and publish them at each frame boundary
    always_ff @(posedge clk)
        if (reset) begin
            acc <= '0;
            collision_mask <= '0;
            collision <= 1'b0;
        end else if (frame_start) begin
            collision_mask <= acc | ovl;
            collision <= |(acc | ovl);
            acc <= '0;
        end else begin
            acc <= acc | ovl;
        end
endmodule
